// File: rtl/pixel_pkg.sv
// Shared types and helpers for the pixel-select path.
// Board geometry, coordinate/board types, direction codes and raster-wrap stepping.
package pixel_pkg;

  localparam int BOARD_DIM = 8;

  typedef logic [2:0] coord_t;
  typedef logic [BOARD_DIM-1:0][BOARD_DIM-1:0] board_t;

  typedef enum logic [1:0] {
    DIR_L,
    DIR_R,
    DIR_U,
    DIR_D
  } dir_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } pos_t;

  // Horizontal steps wrap in raster order (carry/borrow into y);
  // vertical steps wrap within the column. 3-bit math gives mod 8.
  function automatic pos_t wrap_step(coord_t x, coord_t y, dir_t dir);
    pos_t p;
    p.x = x;
    p.y = y;
    case (dir)
      DIR_L: begin
        p.x = x - 3'd1;
        if (x == 3'd0) p.y = y - 3'd1;
      end
      DIR_R: begin
        p.x = x + 3'd1;
        if (x == 3'd7) p.y = y + 3'd1;
      end
      DIR_U: p.y = y - 3'd1;
      DIR_D: p.y = y + 3'd1;
      default: ;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/pixel_cursor_writer_scan.sv
// Row-multiplexed LED matrix scan: walks one active row every SCAN_DIV cycles.
// Ports: i_clk, i_reset (sync, high), i_board, o_row_sel (one-hot), o_col_out.
// CURSOR_BLINK_EN: adds a BLINK_DIV phase that blanks col_out while off.
module led_row_scan
  import pixel_pkg::*;
#(
  parameter int SCAN_DIV = 1000
`ifdef CURSOR_BLINK_EN
  , parameter int BLINK_DIV = 25000000
`endif
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  board_t     i_board,
  output logic [7:0] o_row_sel,
  output logic [7:0] o_col_out
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [SW-1:0] r_cnt;
  logic [2:0]    r_row;
  logic          w_wrap;

  assign w_wrap = (r_cnt == SW'(SCAN_DIV - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
      r_row <= 3'd0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_row <= r_row + 3'd1;
    end else begin
      r_cnt <= r_cnt + SW'(1);
    end
  end

  assign o_row_sel = 8'd1 << r_row;

`ifdef CURSOR_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] r_bcnt;
  logic          r_phase;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bcnt  <= '0;
      r_phase <= 1'b1;
    end else if (r_bcnt == BW'(BLINK_DIV - 1)) begin
      r_bcnt  <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_bcnt <= r_bcnt + BW'(1);
    end
  end

  // The board is one-hot, so blanking the whole row blanks only the cursor.
  assign o_col_out = r_phase ? i_board[r_row] : 8'd0;
`else
  assign o_col_out = i_board[r_row];
`endif

endmodule

// File: rtl/pixel_cursor_writer.sv
// Single-lit-pixel cursor on an 8x8 board: edge-driven moves, load, one-hot board.
// Ports: clk, reset (sync, high), l/r/u/d levels, load/load_x/load_y,
// cur_x/cur_y, pixel_board[y][x], moved pulse, row_sel/col_out LED scan.
// CURSOR_BLINK_EN: blinks the cursor on col_out only (pixel_board unaffected).
module pixel_cursor_writer
  import pixel_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int HOME_X    = 3,
  parameter int HOME_Y    = 3,
  parameter int BLINK_DIV = 25000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            l,
  input  logic            r,
  input  logic            u,
  input  logic            d,
  input  logic            load,
  input  logic [2:0]      load_x,
  input  logic [2:0]      load_y,
  output logic [2:0]      cur_x,
  output logic [2:0]      cur_y,
  output logic [7:0][7:0] pixel_board,
  output logic            moved,
  output logic [7:0]      row_sel,
  output logic [7:0]      col_out
);

  if (SCAN_DIV < 1 || BLINK_DIV < 1) begin : g_bad_div
    $error("SCAN_DIV and BLINK_DIV must be >= 1");
  end
  if (HOME_X < 0 || HOME_X > 7 || HOME_Y < 0 || HOME_Y > 7) begin : g_bad_home
    $error("HOME_X/HOME_Y must be 0..7");
  end

  localparam coord_t HX = coord_t'(HOME_X);
  localparam coord_t HY = coord_t'(HOME_Y);

  coord_t r_x;
  coord_t r_y;
  logic   r_prev_l;
  logic   r_prev_r;
  logic   r_prev_u;
  logic   r_prev_d;
  logic   r_moved;

  logic   w_ev_l;
  logic   w_ev_r;
  logic   w_ev_u;
  logic   w_ev_d;
  pos_t   w_h;
  pos_t   w_nxt;

  assign w_ev_l = l & ~r_prev_l;
  assign w_ev_r = r & ~r_prev_r;
  assign w_ev_u = u & ~r_prev_u;
  assign w_ev_d = d & ~r_prev_d;

  // Horizontal first, then vertical on the horizontal result;
  // opposing events on the same axis cancel. Load overrides both.
  always_comb begin
    w_h = '{x: r_x, y: r_y};
    if (w_ev_l & ~w_ev_r) begin
      w_h = wrap_step(r_x, r_y, DIR_L);
    end else if (w_ev_r & ~w_ev_l) begin
      w_h = wrap_step(r_x, r_y, DIR_R);
    end
    w_nxt = w_h;
    if (w_ev_u & ~w_ev_d) begin
      w_nxt = wrap_step(w_h.x, w_h.y, DIR_U);
    end else if (w_ev_d & ~w_ev_u) begin
      w_nxt = wrap_step(w_h.x, w_h.y, DIR_D);
    end
    if (load) begin
      w_nxt = '{x: load_x, y: load_y};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x      <= HX;
      r_y      <= HY;
      r_prev_l <= 1'b0;
      r_prev_r <= 1'b0;
      r_prev_u <= 1'b0;
      r_prev_d <= 1'b0;
      r_moved  <= 1'b0;
    end else begin
      r_x      <= w_nxt.x;
      r_y      <= w_nxt.y;
      r_prev_l <= l;
      r_prev_r <= r;
      r_prev_u <= u;
      r_prev_d <= d;
      r_moved  <= (w_nxt.x != r_x) || (w_nxt.y != r_y);
    end
  end

  assign cur_x = r_x;
  assign cur_y = r_y;
  assign moved = r_moved;

  always_comb begin
    pixel_board = '0;
    pixel_board[r_y][r_x] = 1'b1;
  end

  led_row_scan #(
    .SCAN_DIV  (SCAN_DIV)
`ifdef CURSOR_BLINK_EN
    , .BLINK_DIV (BLINK_DIV)
`endif
  ) u_scan (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_board   (pixel_board),
    .o_row_sel (row_sel),
    .o_col_out (col_out)
  );

endmodule

// File: doc/pixel_cursor_writer.md
Name: pixel_cursor_writer

Overview:
Writer side of the pixel-select path. Owns the single-lit-pixel cursor on the 8x8 LED board and moves it on l/r/u/d edge requests or a direct coordinate load. Encodes the cursor into the one-hot 8x8 pixel_board consumed by the board-scanning decoder. Also drives the physical LED matrix through a row-multiplexed scan (row_sel/col_out).

Parameters:
SCAN_DIV, 1000, clock cycles each row stays selected during the matrix scan (>=1)
HOME_X, 3, cursor x after reset (0..7)
HOME_Y, 3, cursor y after reset (0..7)
BLINK_DIV, 25000000, cycles per blink half-period (used only with CURSOR_BLINK_EN)

Ports:
clk  in  1  system clock
reset  in  1  reset; synchronous, active-high
l  in  1  move-left request level, already synchronised; acted on at its rising edge
r  in  1  move-right request level, rising-edge acted
u  in  1  move-up request level, rising-edge acted
d  in  1  move-down request level, rising-edge acted
load  in  1  single-cycle load strobe
load_x  in  3  column to load
load_y  in  3  row to load
cur_x  out  3  registered cursor column
cur_y  out  3  registered cursor row
pixel_board  out  8x8  pixel_board[y][x]; exactly one bit high, at [cur_y][cur_x]
moved  out  1  one-cycle pulse when the cursor changed
row_sel  out  8  one-hot active-high row drive for the LED matrix
col_out  out  8  column data for the selected row = pixel_board[scan_row]

Behaviour:
- Reset (sync): cursor = (HOME_X, HOME_Y); edge-detect history regs = 0; scan_row = 0; scan counter = 0; moved = 0; row_sel = 8'b0000_0001; pixel_board one-hot at [HOME_Y][HOME_X]. Reset overrides every other input in the same cycle.
- Edge detect: each of l/r/u/d has a prev register. An event is in AND NOT prev. A held level produces one event only.
- Update priority in cycle N; result is visible in cur_x/cur_y/pixel_board after the next clock edge (1-cycle latency):
  1. load: cursor <= (load_x, load_y). Move events this cycle are discarded; prev registers still update.
  2. Otherwise, horizontal: l-event only -> x-1; r-event only -> x+1; both or neither -> no horizontal move.
  3. Horizontal wrap is raster order. x=7 with r gives x=0, y=y+1 mod 8. x=0 with l gives x=7, y=y-1 mod 8. (7,7) with r gives (0,0); (0,0) with l gives (7,7).
  4. Vertical: u-event only -> y-1 mod 8; d-event only -> y+1 mod 8; both -> none. Vertical is applied after the horizontal result, on the same cycle.
- moved = 1 for one cycle, registered alongside the cursor, only when the new cursor differs from the old one. A load to the current position gives moved = 0.
- pixel_board is combinational from the cursor regs only: 64-bit one-hot, never zero, never multi-hot.
- Scan:
  - Counter counts 0..SCAN_DIV-1. On wrap, scan_row increments mod 8.
  - row_sel = 1 << scan_row. col_out = pixel_board[scan_row], so it changes with the cursor mid-row.
  - The scan runs independently of moves.

Optional Feature:
CURSOR_BLINK_EN
- Defined: a BLINK_DIV counter toggles a phase bit (reset phase = on). While phase is off, the cursor bit is masked to 0 in col_out only. pixel_board stays one-hot so the decoder is never starved.
- Undefined: no blink counter is present; col_out is unmasked.

Decomposition:
- Shared package pixel_pkg:
  - BOARD_DIM = 8
  - coord_t = logic [2:0]
  - board_t = logic [7:0][7:0]
  - function wrap_step(coord_t x, coord_t y, dir) returning the raster-wrapped next coordinate
- Sub-module led_row_scan: scan counter, scan_row, row_sel and col_out select (and blink mask when enabled). The cursor/edge-detect logic stays in pixel_cursor_writer.

Test Plan:
- Reset with HOME=(3,3) -> cur=(3,3), pixel_board[3][3]=1 only, row_sel=8'h01, moved=0.
- r held high 10 cycles from (3,3) -> exactly one move, to (4,3); moved pulses 1 cycle; pixel_board[3][4]=1.
- Wrap cases:
  - From (7,2), pulse r -> (0,3).
  - From (0,0), pulse l -> (7,7).
  - From (5,0), pulse u -> (5,7).
- Conflicts:
  - l and r rise together at (2,2) -> cursor unchanged, moved=0.
  - load=1 with (6,1) while d rises -> (6,1), d discarded.
  - load to the current position -> moved=0.
- SCAN_DIV=4, cursor (1,5): row_sel walks 01,02,…,80,01 each 4 cycles; col_out=8'h02 only while row_sel=8'h20, else 0.
- Reset asserted mid-scan and mid-move -> next cycle cur=(HOME_X,HOME_Y), row_sel=8'h01. With CURSOR_BLINK_EN and BLINK_DIV=3: col_out cursor bit toggles every 3 cycles, pixel_board stays constant.
